// File: rtl/turn_ctrl_if.sv
// Player-side bundle for the tic-tac-toe sequencer: move requests in,
// acknowledges, coordinate-register write port and board/status out.
interface turn_ctrl_if;
  logic       new_game;
  logic       p1_req;
  logic [3:0] p1_coord;
  logic       p2_req;
  logic [3:0] p2_coord;
  logic       p1_ack;
  logic       p2_ack;
  logic       reject;
  logic       timeout;
  logic       coord_we;
  logic [3:0] coord_out;
  logic [8:0] p1_cells;
  logic [8:0] p2_cells;
  logic       turn;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output new_game, p1_req, p1_coord, p2_req, p2_coord,
    input  p1_ack, p2_ack, reject, timeout, coord_we, coord_out,
    input  p1_cells, p2_cells, turn, game_over, winner
  );

  modport slave (
    input  new_game, p1_req, p1_coord, p2_req, p2_coord,
    output p1_ack, p2_ack, reject, timeout, coord_we, coord_out,
    output p1_cells, p2_cells, turn, game_over, winner
  );
endinterface

// File: rtl/turn_ctrl.sv
// Two-player tic-tac-toe turn sequencer: arbitrates and validates moves,
// drives the coordinate register write port, tracks the board and detects win/draw.
module turn_ctrl #(
  parameter int unsigned FIRST_PLAYER   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  turn_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StWait, StCommit, StCheck, StOver} state_e;

  localparam logic             FirstTurn = (FIRST_PLAYER != 0);
  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             turn_q, turn_d;
  logic [8:0]       p1_cells_q, p1_cells_d;
  logic [8:0]       p2_cells_q, p2_cells_d;
  logic [1:0]       winner_q, winner_d;
  logic [3:0]       coord_q, coord_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reject_q, reject_d;
  logic             timeout_q, timeout_d;

  logic             cur_req;
  logic [3:0]       cur_coord;
  logic [8:0]       occ;
  logic [15:0]      occ_ext;
  logic             valid;
  logic [8:0]       mover_mask;

  function automatic logic line_done(input logic [8:0] m);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  // Only the player whose turn it is gets looked at; the other is ignored silently.
  assign cur_req    = turn_q ? bus.p2_req : bus.p1_req;
  assign cur_coord  = turn_q ? bus.p2_coord : bus.p1_coord;
  assign occ        = p1_cells_q | p2_cells_q;
  assign occ_ext    = {7'b0, occ};
  assign valid      = cur_req && (cur_coord <= 4'd8) && !occ_ext[cur_coord];
  assign mover_mask = turn_q ? p2_cells_q : p1_cells_q;

  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    p1_cells_d = p1_cells_q;
    p2_cells_d = p2_cells_q;
    winner_d   = winner_q;
    coord_d    = coord_q;
    cnt_d      = cnt_q;
    reject_d   = 1'b0;
    timeout_d  = 1'b0;

    if (bus.new_game) begin
      // Leaving COMMIT here aborts the move before its mask bit is written.
      state_d    = StWait;
      turn_d     = FirstTurn;
      p1_cells_d = '0;
      p2_cells_d = '0;
      winner_d   = 2'b00;
      coord_d    = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        StWait: begin
          if (valid) begin
            coord_d = cur_coord;
            state_d = StCommit;
          end else begin
            reject_d = cur_req;
            if (TIMEOUT_CYCLES != 0) begin
              if (cnt_q == CntLast) begin
                timeout_d = 1'b1;
                turn_d    = ~turn_q;
                cnt_d     = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
        end
        StCommit: begin
          if (turn_q) p2_cells_d = p2_cells_q | (9'd1 << coord_q);
          else        p1_cells_d = p1_cells_q | (9'd1 << coord_q);
          state_d = StCheck;
        end
        StCheck: begin
          if (line_done(mover_mask)) begin
            winner_d = turn_q ? 2'b10 : 2'b01;
            state_d  = StOver;
          end else if (&occ) begin
            winner_d = 2'b11;
            state_d  = StOver;
          end else begin
            turn_d  = ~turn_q;
            cnt_d   = '0;
            state_d = StWait;
          end
        end
        StOver:  state_d = StOver;
        default: state_d = StWait;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWait;
      turn_q     <= FirstTurn;
      p1_cells_q <= '0;
      p2_cells_q <= '0;
      winner_q   <= 2'b00;
      coord_q    <= '0;
      cnt_q      <= '0;
      reject_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      p1_cells_q <= p1_cells_d;
      p2_cells_q <= p2_cells_d;
      winner_q   <= winner_d;
      coord_q    <= coord_d;
      cnt_q      <= cnt_d;
      reject_q   <= reject_d;
      timeout_q  <= timeout_d;
    end
  end

  // Write enable and acks decode from state, so reset drops them immediately.
  assign bus.coord_we  = (state_q == StCommit);
  assign bus.p1_ack    = (state_q == StCommit) && !turn_q;
  assign bus.p2_ack    = (state_q == StCommit) && turn_q;
  assign bus.game_over = (state_q == StOver);
  assign bus.reject    = reject_q;
  assign bus.timeout   = timeout_q;
  assign bus.coord_out = coord_q;
  assign bus.p1_cells  = p1_cells_q;
  assign bus.p2_cells  = p2_cells_q;
  assign bus.turn      = turn_q;
  assign bus.winner    = winner_q;

endmodule
